disp_scan: RTL

- Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
- Holds a 16-bit hex value and selects one digit at a time via active-low anodes.
- Presents that digit's 4-bit nibble to the downstream 7-segment decoder and blanks all anodes between digits to prevent ghosting.
- New values are double-buffered and committed only at frame boundaries, so a frame never shows a partially updated value.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/disp_scan_if.sv | 23 ++
 rtl/disp_tick_cnt.sv | 36 +++
 rtl/disp_scan.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment display scanner.
package disp_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 32;

    // All-anodes-off pattern (active-low) for the low n digits.
    function automatic logic [MAX_DIGITS-1:0] anodes_off(input int unsigned n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Load/value handshake and display outputs of the scanner.
interface disp_scan_if
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4
);
    logic                          load_i;
    logic [DIGIT_W*N_DIGITS-1:0]   value_i;
    logic [DIGIT_W-1:0]            nibble_o;
    logic [N_DIGITS-1:0]           an_o;
    logic                          pending_o;
    logic                          commit_o;

    modport master (
        output load_i, value_i,
        input  nibble_o, an_o, pending_o, commit_o
    );

    modport slave (
        input  load_i, value_i,
        output nibble_o, an_o, pending_o, commit_o
    );
endinterface

// File: rtl/disp_tick_cnt.sv
// Shared dwell counter: counts up from zero, flags the terminal value selected
// by sel_a (TERM_A when high, TERM_B when low), cleared by the owner on state change.
module disp_tick_cnt #(
    parameter int unsigned TERM_A = 1,
    parameter int unsigned TERM_B = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sel_a,
    output logic tc
);
    localparam int unsigned TMAX = (TERM_A > TERM_B) ? TERM_A : TERM_B;
    localparam int unsigned CW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
    localparam logic [CW-1:0] TA = CW'(TERM_A);
    localparam logic [CW-1:0] TB = CW'(TERM_B);

    logic [CW-1:0] cnt;

    // Count register: cleared on reset or by the owning FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal-count decode against the selected limit.
    always_comb begin
        tc = (cnt == (sel_a ? TA : TB));
    end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment display.
// Double-buffered value: loads land in a shadow register and are committed
// to the display register only at the frame boundary.
// Optional macro DISP_SCAN_LZB_EN: leading-zero blanking (digit 0 always lit).
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned CLKS_PER_DIGIT = 27000,
    parameter int unsigned BLANK_CLKS     = 16
) (
    input  logic       clk,
    input  logic       rst,
    disp_scan_if.slave bus
);
    localparam int unsigned            VAL_W      = DIGIT_W * N_DIGITS;
    localparam int unsigned            IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0]  AN_OFF_ALL = anodes_off(N_DIGITS);
    localparam logic [N_DIGITS-1:0]    AN_OFF     = AN_OFF_ALL[N_DIGITS-1:0];
    localparam logic [N_DIGITS-1:0]    AN_ONE     = N_DIGITS'(1);

    scan_state_t          state_q, state_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic                 first_q, first_n;
    logic [VAL_W-1:0]     disp_q, disp_n;
    logic [VAL_W-1:0]     shadow_q, shadow_n;
    logic                 pending_q, pending_n;
    logic [N_DIGITS-1:0]  an_q, an_n;
    logic [DIGIT_W-1:0]   nib_q, nib_n;
    logic                 commit_q, commit_n;
    logic                 cnt_clr, cnt_tc, cnt_sel_show;
    logic                 lz_blank;

`ifdef DISP_SCAN_LZB_EN
    // True when digit d is not digit 0 and every digit from d upwards is zero.
    function automatic logic leading_zero(input logic [VAL_W-1:0] v,
                                          input logic [IDX_W-1:0] d);
        logic nz;
        nz = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (i >= 32'(d) && v[i*DIGIT_W +: DIGIT_W] != '0) begin
                nz = 1'b1;
            end
        end
        return (d != '0) && !nz;
    endfunction
`endif

    disp_tick_cnt #(
        .TERM_A (CLKS_PER_DIGIT - 1),
        .TERM_B (BLANK_CLKS - 1)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .sel_a (cnt_sel_show),
        .tc    (cnt_tc)
    );

    // State, buffers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= GAP;
            idx_q     <= '0;
            first_q   <= 1'b1;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            an_q      <= AN_OFF;
            nib_q     <= '0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            first_q   <= first_n;
            disp_q    <= disp_n;
            shadow_q  <= shadow_n;
            pending_q <= pending_n;
            an_q      <= an_n;
            nib_q     <= nib_n;
            commit_q  <= commit_n;
        end
    end

    // Next-state, commit/load handling and next-output decode.
    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself (anodes go dark in the cycle GAP is entered).
    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        first_n      = first_q;
        disp_n       = disp_q;
        shadow_n     = shadow_q;
        pending_n    = pending_q;
        commit_n     = 1'b0;
        cnt_clr      = 1'b0;
        cnt_sel_show = (state_q == SHOW);
        an_n         = AN_OFF;
        nib_n        = nib_q;
        lz_blank     = 1'b0;

        case (state_q)
            SHOW: begin
                if (cnt_tc) begin
                    state_n = GAP;
                    cnt_clr = 1'b1;
                end
            end
            GAP: begin
                if (cnt_tc) begin
                    state_n = SHOW;
                    cnt_clr = 1'b1;
                    first_n = 1'b0;
                    if (!first_q) begin
                        idx_n = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end
                    if (idx_q == IDX_LAST && pending_q) begin
                        disp_n    = shadow_q;
                        pending_n = 1'b0;
                        commit_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = GAP;
                cnt_clr = 1'b1;
            end
        endcase

        // A load on the commit cycle overrides the pending clear above.
        if (bus.load_i) begin
            shadow_n  = bus.value_i;
            pending_n = 1'b1;
        end

        if (state_n == SHOW) begin
`ifdef DISP_SCAN_LZB_EN
            lz_blank = leading_zero(disp_n, idx_n);
`endif
            nib_n = disp_n[DIGIT_W*idx_n +: DIGIT_W];
            if (!lz_blank) begin
                an_n = ~(AN_ONE << idx_n);
            end
        end
    end

    assign bus.an_o      = an_q;
    assign bus.nibble_o  = nib_q;
    assign bus.pending_o = pending_q;
    assign bus.commit_o  = commit_q;

endmodule
